inst_byte_loader: RTL
=====================

INST_BYTE_LOADER -- requirements
Module: inst_byte_loader

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the instruction-memory word-address width; DEPTH = 2^ADDR_W words.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port load_req, input, 1: a rising edge requests a load session; the level must stay high for the whole session.
REQ-005 Port num_words, input, ADDR_W+1: word count for the session, sampled on the load_req rising edge.
REQ-006 Port byte_in, input, 8: instruction byte stream.
REQ-007 Port byte_valid, input, 1: byte_in holds a valid byte this cycle.
REQ-008 Port byte_ready, output, 1: the loader accepts byte_in this cycle.
REQ-009 Port mem_we, output, 1: one-cycle write strobe to the instruction memory.
REQ-010 Port mem_addr, output, ADDR_W: word address for the write.
REQ-011 Port mem_wdata, output, 32: assembled instruction word.
REQ-012 Port cpu_rst_n, output, 1: active-low hold for the core; low means the core is held in reset.
REQ-013 Port busy, output, 1: a session is in progress.
REQ-014 Port done, output, 1: one-cycle pulse when a session completes successfully.
REQ-015 Port err, output, 1: one-cycle pulse when a session is rejected or aborted.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE and FINISH; busy SHALL be 1 in COLLECT and WRITE.
REQ-017 IDLE: a rising edge of load_req (low in the previous cycle, high now) with 1 <= num_words <= DEPTH SHALL go to COLLECT, latch num_words, and clear the word counter, byte index and mem_addr.
REQ-018 IDLE: a load_req rising edge with num_words = 0 or num_words > DEPTH SHALL pulse err the next cycle and stay in IDLE.
REQ-019 byte_ready SHALL equal 1 only in COLLECT; a byte is accepted when byte_valid && byte_ready.
REQ-020 Byte order is little-endian: accepted byte k of a word (k = 0..3) SHALL land in bits [8k+7:8k].
REQ-021 The 4th accepted byte SHALL move the FSM to WRITE; byte_valid without byte_ready SHALL have no effect.
REQ-022 WRITE lasts exactly one cycle, with mem_we = 1, mem_addr = the current word index, and mem_wdata = the assembled word.
REQ-023 Latency: 4th byte accepted at edge N -> mem_we high in cycle N+1.
REQ-024 Leaving WRITE: mem_addr SHALL increment and the word counter SHALL increment.
REQ-025 Leaving WRITE: if word counter + 1 equals the latched num_words, go to FINISH; otherwise go back to COLLECT with the byte index at 0.
REQ-026 FINISH SHALL last one cycle: done = 1, the loaded flag is set, then go to IDLE.
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their values when mem_we = 0.
REQ-028 cpu_rst_n SHALL be 1 only when the loaded flag is set and the state is IDLE; any new session start SHALL drive it low again.
REQ-029 Abort: load_req low while in COLLECT or WRITE SHALL discard any partial word, clear the loaded flag, pulse err, and go to IDLE.
REQ-030 Abort in WRITE: the write in progress SHALL still complete in that cycle, then the abort applies.
REQ-031 load_req held high after FINISH SHALL NOT start a new session; a new low-to-high transition is required.
REQ-032 Simultaneous load_req rising edge and byte_valid in IDLE: the byte SHALL NOT be accepted (byte_ready = 0).
REQ-033 A session of DEPTH words SHALL write addresses 0..DEPTH-1; mem_addr SHALL wrap to 0 after the final increment and SHALL never be written out of range.

Reset
REQ-034 rst_n low at a clock edge SHALL return the FSM to IDLE from any state, including mid-word and mid-WRITE.
REQ-035 Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0, loaded flag=0, byte index=0, word counter=0, and the load_req edge-detect register=1 (so a load_req already high out of reset does not start a session).
REQ-036 A partial word SHALL never be written after reset.

Verification
REQ-037 num_words=2, bytes 13,00,00,00,93,00,10,00 sent back-to-back -> writes addr0=0x00000013 and addr1=0x00100093, done pulses 1 cycle after the second mem_we, then cpu_rst_n=1.
REQ-038 num_words=1, bytes 0x78,0x56,0x34,0x12 with byte_valid gaps of 2 cycles -> a single write of 0x12345678 at addr0 and no spurious mem_we.
REQ-039 num_words=0 and num_words=DEPTH+1 -> err pulses once each, busy stays 0, and no mem_we occurs.
REQ-040 num_words=3, load_req dropped after 6 bytes -> only addr0 is written, err pulses, cpu_rst_n=0, and a subsequent full load of 3 words succeeds.
REQ-041 rst_n asserted after 2 bytes of a word -> all outputs at reset values next cycle; reload from addr0 gives correct data.
REQ-042 num_words=DEPTH (32) with incrementing bytes -> addresses 0..31 written in order, done pulses once, and mem_addr returns to 0.

Source files
------------

// File: rtl/inst_byte_loader_if.sv
// inst_byte_loader_if: byte-stream, memory-write and status signals of the instruction loader
interface inst_byte_loader_if #(parameter int ADDR_W = 5);
   logic              load_req;
   logic [ADDR_W:0]   num_words;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic              err;
   modport master (
      output load_req, num_words, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
   );
   modport slave (
      input  load_req, num_words, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
   );
endinterface

// File: rtl/inst_byte_loader.sv
// inst_byte_loader: assembles little-endian byte stream into 32-bit words and writes them to instruction memory
module inst_byte_loader #(parameter int ADDR_W = 5) (
   input logic               clk,
   input logic               rst_n,
   inst_byte_loader_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;
   state_t            state, nxt;
   logic              req_q, err_q, loaded;
   logic              rise, start, reject, abort, accept, last;
   logic [ADDR_W:0]   n_words, word_cnt;
   logic [1:0]        byte_idx;
   logic [23:0]       word_buf;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   assign bus.byte_ready = state == COLLECT;
   assign bus.mem_we     = state == WRITE;
   assign bus.busy       = state == COLLECT || state == WRITE;
   assign bus.done       = state == FINISH;
   assign bus.err        = err_q;
   assign bus.cpu_rst_n  = loaded && state == IDLE;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   // session start/reject/abort decode and next-state selection
   always_comb begin
      rise   = bus.load_req && !req_q;
      start  = state == IDLE && rise && bus.num_words != '0 && bus.num_words <= DEPTH;
      reject = state == IDLE && rise && !start;
      abort  = (state == COLLECT || state == WRITE) && !bus.load_req;
      accept = state == COLLECT && bus.byte_valid && bus.load_req;
      last   = word_cnt + (ADDR_W+1)'(1) == n_words;
      nxt    = state;
      case (state)
         IDLE:    nxt = start ? COLLECT : IDLE;
         COLLECT: nxt = abort ? IDLE : (accept && byte_idx == 2'd3) ? WRITE : COLLECT;
         WRITE:   nxt = abort ? IDLE : last ? FINISH : COLLECT;
         default: nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end
   // word assembly, write address/data, counters and loaded flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q    <= 1'b1;
         err_q    <= 1'b0;
         loaded   <= 1'b0;
         n_words  <= '0;
         word_cnt <= '0;
         byte_idx <= '0;
         word_buf <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         req_q <= bus.load_req;
         err_q <= reject || abort;
         if (start) begin
            n_words  <= bus.num_words;
            word_cnt <= '0;
            byte_idx <= '0;
            addr_q   <= '0;
            loaded   <= 1'b0;
         end
         if (accept && !abort) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) wdata_q <= {bus.byte_in, word_buf};
            else word_buf[{byte_idx, 3'b000} +: 8] <= bus.byte_in;
         end
         if (state == WRITE && !abort) begin
            addr_q   <= addr_q + ADDR_W'(1);
            word_cnt <= word_cnt + (ADDR_W+1)'(1);
            byte_idx <= '0;
         end
         if (abort) begin
            byte_idx <= '0;
            loaded   <= 1'b0;
         end
         if (state == FINISH) loaded <= 1'b1;
      end
   end
endmodule
